// File: rtl/timer_pkg.sv
// Shared register map, CTRL bit positions and mode encoding for the timer bank.
package timer_pkg;
    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_RELOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT    = 2'd2;
    localparam logic [1:0] REG_PRESCALE = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IE   = 2;
    localparam int CTRL_FLAG = 3;

    typedef enum logic {
        MODE_AUTO    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_e;
endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, up-counter with reload, CTRL bits and sticky overflow flag.
// Register writes take effect on the next edge; intrup is registered from flag & ie.
module timer_channel
    import timer_pkg::*;
#(
    parameter int TIMERWID = 16,
    parameter int PREWID   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_ctrl,
    input  logic                wr_reload,
    input  logic                wr_count,
    input  logic                wr_prescale,
    input  logic [TIMERWID-1:0] wdata,
    output logic [TIMERWID-1:0] ctrl,
    output logic [TIMERWID-1:0] reload,
    output logic [TIMERWID-1:0] count,
    output logic [TIMERWID-1:0] prescale,
    output logic                intrup
);
    logic              en;
    logic              ie;
    logic              flag;
    mode_e             mode;
    logic [PREWID-1:0] pre_cnt;
    logic [PREWID-1:0] pre_val;
    logic              tick;
    logic              ovf;

    assign tick = en && (pre_cnt == pre_val);
    // A software COUNT write in the tick cycle suppresses both increment and overflow.
    assign ovf  = tick && (&count) && !wr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            flag    <= 1'b0;
            mode    <= MODE_AUTO;
            pre_cnt <= '0;
            pre_val <= '0;
            reload  <= '0;
            count   <= '0;
            intrup  <= 1'b0;
        end else begin
            if (wr_prescale || !en || tick)
                pre_cnt <= '0;
            else
                pre_cnt <= pre_cnt + 1'b1;

            if (wr_prescale)
                pre_val <= PREWID'(wdata);
            if (wr_reload)
                reload <= wdata;

            if (wr_count)
                count <= wdata;
            else if (ovf)
                count <= reload;
            else if (tick)
                count <= count + 1'b1;

            if (wr_ctrl) begin
                en   <= wdata[CTRL_EN];
                mode <= mode_e'(wdata[CTRL_MODE]);
                ie   <= wdata[CTRL_IE];
            end
            // One-shot expiry overrides any enable written in the same cycle.
            if (ovf && mode == MODE_ONESHOT)
                en <= 1'b0;

            if (ovf)
                flag <= 1'b1;
            else if (wr_ctrl && wdata[CTRL_FLAG])
                flag <= 1'b0;

            intrup <= flag & ie;
        end
    end

    assign ctrl     = TIMERWID'({flag, ie, mode, en});
    assign prescale = TIMERWID'(pre_val);
endmodule

// File: rtl/timer_bank.sv
// Multi-channel memory-mapped timer bank: address decode, read mux, registered dataout, irq OR.
// Reads return data one clock after cs&rd; writes are single-cycle, no stalls.
module timer_bank
    import timer_pkg::*;
#(
    parameter int TIMERWID = 16,
    parameter int NCH      = 2,
    parameter int PREWID   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [$clog2(NCH)+1:0] addr,
    input  logic [TIMERWID-1:0]   datain,
    output logic [TIMERWID-1:0]   dataout,
    output logic [NCH-1:0]        intrup,
    output logic                  irq
);
    localparam int CW  = $clog2(NCH);
    localparam int CWX = (CW > 0) ? CW : 1;

    logic [CWX-1:0]      ch_sel;
    logic [1:0]          reg_sel;
    logic                ch_ok;
    logic                wr_hit;
    logic [TIMERWID-1:0] rdata;
    logic [TIMERWID-1:0] ctrl_q     [NCH];
    logic [TIMERWID-1:0] reload_q   [NCH];
    logic [TIMERWID-1:0] count_q    [NCH];
    logic [TIMERWID-1:0] prescale_q [NCH];

    assign reg_sel = addr[1:0];

    generate
        if (CW > 0) begin : g_chsel
            assign ch_sel = addr[CW+1:2];
        end else begin : g_nochsel
            assign ch_sel = '0;
        end
    endgenerate

    // Non-power-of-two NCH leaves holes in the channel field; those decode to nothing.
    assign ch_ok  = ({1'b0, ch_sel} < (CWX+1)'(NCH));
    assign wr_hit = cs && wr && ch_ok;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            logic sel;
            assign sel = wr_hit && (ch_sel == CWX'(i));

            timer_channel #(
                .TIMERWID (TIMERWID),
                .PREWID   (PREWID)
            ) u_ch (
                .clk         (clk),
                .rst_n       (rst_n),
                .wr_ctrl     (sel && reg_sel == REG_CTRL),
                .wr_reload   (sel && reg_sel == REG_RELOAD),
                .wr_count    (sel && reg_sel == REG_COUNT),
                .wr_prescale (sel && reg_sel == REG_PRESCALE),
                .wdata       (datain),
                .ctrl        (ctrl_q[i]),
                .reload      (reload_q[i]),
                .count       (count_q[i]),
                .prescale    (prescale_q[i]),
                .intrup      (intrup[i])
            );
        end
    endgenerate

    always_comb begin
        rdata = '0;
        if (ch_ok) begin
            case (reg_sel)
                REG_CTRL:     rdata = ctrl_q[ch_sel];
                REG_RELOAD:   rdata = reload_q[ch_sel];
                REG_COUNT:    rdata = count_q[ch_sel];
                REG_PRESCALE: rdata = prescale_q[ch_sel];
                default:      rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dataout <= '0;
        else if (cs && rd)
            dataout <= rdata;
    end

    assign irq = |intrup;
endmodule
